// File: rtl/lc3_operate_ctrl.sv
// LC-3 operate-instruction sequencer: decodes ADD/AND/NOT, drives the registered ALU,
// writes the result back and maintains the N/Z/P condition codes.
module lc3_operate_ctrl #(
  parameter logic [2:0] NZP_RST     = 3'b010,
  parameter bit         CHK_NOT_ONE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  sr1_addr,
  output logic [2:0]  sr2_addr,
  input  logic [15:0] sr1_data,
  input  logic [15:0] sr2_data,
  output logic [1:0]  alu_k,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        gate_alu,
  input  logic [15:0] alu_out,
  output logic        dr_we,
  output logic [2:0]  dr_addr,
  output logic [15:0] dr_data,
  output logic [2:0]  nzp,
  output logic        done,
  output logic        ill_op
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [2:0]  r_nzp;
  logic        w_legal;

  // Legality is judged on the incoming word so the IDLE->EXEC/ERR decision
  // is made in the same edge that latches it into r_ir.
  always_comb begin
    w_legal = 1'b0;
    case (instr[15:12])
      OP_ADD, OP_AND: w_legal = 1'b1;
      OP_NOT:         w_legal = !CHK_NOT_ONE || (instr[5:0] == 6'h3F);
      default:        w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_next = w_legal ? S_EXEC : S_ERR;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir <= '0;
    end else if (r_state == S_IDLE && instr_valid) begin
      r_ir <= instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nzp <= NZP_RST;
    end else if (r_state == S_WB) begin
      if (alu_out[15])          r_nzp <= 3'b100;
      else if (alu_out == '0)   r_nzp <= 3'b010;
      else                      r_nzp <= 3'b001;
    end
  end

  always_comb begin
    instr_ready = 1'b0;
    sr1_addr    = '0;
    sr2_addr    = '0;
    alu_k       = 2'b11;
    op_a        = '0;
    op_b        = '0;
    gate_alu    = 1'b0;
    dr_we       = 1'b0;
    dr_addr     = '0;
    dr_data     = '0;
    done        = 1'b0;
    ill_op      = 1'b0;
    case (r_state)
      S_IDLE: instr_ready = 1'b1;
      S_EXEC: begin
        sr1_addr = r_ir[8:6];
        sr2_addr = r_ir[2:0];
        op_a     = sr1_data;
        case (r_ir[15:12])
          OP_ADD:  alu_k = 2'b00;
          OP_AND:  alu_k = 2'b01;
          default: alu_k = 2'b10;
        endcase
        if (r_ir[15:12] != OP_NOT)
          op_b = r_ir[5] ? {{11{r_ir[4]}}, r_ir[4:0]} : sr2_data;
      end
      S_WB: begin
        gate_alu = 1'b1;
        dr_we    = 1'b1;
        dr_addr  = r_ir[11:9];
        dr_data  = alu_out;
        done     = 1'b1;
      end
      S_ERR:   ill_op = 1'b1;
      default: ;
    endcase
  end

  assign nzp = r_nzp;

endmodule

// File: tb/tb_lc3_operate_ctrl.sv
// Scoreboard bench for lc3_operate_ctrl with a behavioural register file and registered ALU.
module tb_lc3_operate_ctrl;

  localparam logic [2:0] NZP_RST = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  sr1_addr, sr2_addr;
  logic [15:0] sr1_data, sr2_data;
  logic [1:0]  alu_k;
  logic [15:0] op_a, op_b;
  logic        gate_alu;
  logic [15:0] alu_out;
  logic        dr_we;
  logic [2:0]  dr_addr;
  logic [15:0] dr_data;
  logic [2:0]  nzp;
  logic        done;
  logic        ill_op;

  lc3_operate_ctrl #(.NZP_RST(NZP_RST), .CHK_NOT_ONE(1'b1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .sr1_addr(sr1_addr), .sr2_addr(sr2_addr),
    .sr1_data(sr1_data), .sr2_data(sr2_data), .alu_k(alu_k), .op_a(op_a),
    .op_b(op_b), .gate_alu(gate_alu), .alu_out(alu_out), .dr_we(dr_we),
    .dr_addr(dr_addr), .dr_data(dr_data), .nzp(nzp), .done(done), .ill_op(ill_op)
  );

  always #5 clk = ~clk;

  // Environment: register file (comb read) and 1-cycle registered ALU
  logic [15:0] rf [8];
  logic [15:0] r_alu;
  logic        bd_we;
  logic [2:0]  bd_addr;
  logic [15:0] bd_data;

  assign sr1_data = rf[sr1_addr];
  assign sr2_data = rf[sr2_addr];
  assign alu_out  = r_alu;

  always @(posedge clk) begin
    case (alu_k)
      2'b00:   r_alu <= op_a + op_b;
      2'b01:   r_alu <= op_a & op_b;
      2'b10:   r_alu <= ~op_a;
      default: r_alu <= op_a;
    endcase
    if (bd_we)      rf[bd_addr] <= bd_data;
    else if (dr_we) rf[dr_addr] <= dr_data;
  end

  typedef struct {
    bit          ill;
    logic [2:0]  dr;
    logic [15:0] res;
    logic [2:0]  nzp;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mr [8];
  logic [2:0]  mnzp = NZP_RST;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          b2b = 1'b0;
  bit          have_last = 1'b0;
  int          last_acc = 0;
  bit          last_ill = 1'b0;
  bit          nzp_pend = 1'b0;
  logic [2:0]  nzp_exp = NZP_RST;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: architectural effect of one instruction on the model state
  function automatic exp_t model(input logic [15:0] w, input int c);
    exp_t        e;
    logic [15:0] a, b;
    int          imm;
    imm   = int'($signed(w[4:0]));
    a     = mr[w[8:6]];
    b     = w[5] ? 16'(imm) : mr[w[2:0]];
    e.ill = 1'b0;
    e.dr  = w[11:9];
    e.res = '0;
    case (w[15:12])
      4'd1: e.res = 16'(a + b);
      4'd5: e.res = a & b;
      4'd9: begin
        e.res = ~a;
        if (w[5:0] != 6'h3F) e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if ($signed(e.res) < 0) e.nzp = 3'b100;
    else if (e.res == 0)    e.nzp = 3'b010;
    else                    e.nzp = 3'b001;
    e.cyc = c + (e.ill ? 1 : 2);
    return e;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        mnzp      = NZP_RST;
        nzp_pend  = 1'b0;
        have_last = 1'b0;
        continue;
      end
      cyc++;
      if (bd_we) mr[bd_addr] = bd_data;
      if (nzp_pend) begin
        check("nzp", 32'(nzp), 32'(nzp_exp));
        nzp_pend = 1'b0;
      end
      if (q.size() > 0 && q[0].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_event: actual=none required=event at cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      if (done || ill_op) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: actual done=%0b ill_op=%0b required=none", done, ill_op);
        end else begin
          e = q.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          check("ill_op", 32'(ill_op), 32'(e.ill));
          check("done", 32'(done), 32'(!e.ill));
          check("dr_we", 32'(dr_we), 32'(!e.ill));
          if (!e.ill) begin
            check("dr_addr", 32'(dr_addr), 32'(e.dr));
            check("dr_data", 32'(dr_data), 32'(e.res));
            mr[e.dr] = e.res;
            mnzp     = e.nzp;
          end
          nzp_pend = 1'b1;
          nzp_exp  = mnzp;
        end
      end
      if (instr_valid && instr_ready) begin
        e = model(instr, cyc);
        if (b2b) begin
          if (have_last) check("accept_gap", 32'(cyc - last_acc), last_ill ? 32'd2 : 32'd3);
          have_last = 1'b1;
          last_acc  = cyc;
          last_ill  = e.ill;
        end else begin
          have_last = 1'b0;
        end
        q.push_back(e);
      end
    end
  end

  task automatic setreg(input int idx, input logic [15:0] v);
    bd_we   = 1'b1;
    bd_addr = 3'(idx);
    bd_data = v;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w);
    bit acc;
    instr       = w;
    instr_valid = 1'b1;
    acc         = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (instr_ready) acc = 1'b1;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: actual instr_ready=0 required=1 for %h", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() != 0 || nzp_pend); i++) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: actual pending=%0d required=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    instr       = '0;
    instr_valid = 1'b0;
    bd_we       = 1'b0;
    bd_addr     = '0;
    bd_data     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_instr_ready", 32'(instr_ready), 32'd1);
    check("rst_nzp", 32'(nzp), 32'(NZP_RST));
    check("rst_done", 32'(done), 32'd0);
    check("rst_ill_op", 32'(ill_op), 32'd0);
    check("rst_dr_we", 32'(dr_we), 32'd0);
    check("rst_gate_alu", 32'(gate_alu), 32'd0);
    check("rst_alu_k", 32'(alu_k), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) setreg(i, 16'($urandom));
    setreg(1, 16'd5);
    setreg(2, 16'd3);

    issue(16'h1042); instr_valid = 1'b0; drain();
    issue(16'h1670); instr_valid = 1'b0; drain();
    issue(16'h5860); instr_valid = 1'b0; drain();
    issue(16'h9A7F); instr_valid = 1'b0; drain();
    issue(16'h1042); instr_valid = 1'b0; drain();
    issue(16'h0E05); instr_valid = 1'b0; drain();
    issue(16'h9A40); instr_valid = 1'b0; drain();

    // instr_valid held high across back-to-back ADDs
    b2b = 1'b1;
    issue(16'h1042);
    issue(16'h1261);
    issue(16'h1440);
    instr_valid = 1'b0;
    drain();
    b2b = 1'b0;

    // Asynchronous reset in the EXEC cycle aborts the writeback
    setreg(0, 16'h1234);
    setreg(1, 16'd5);
    setreg(2, 16'd3);
    issue(16'h1042);
    instr_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("abort_instr_ready", 32'(instr_ready), 32'd1);
    check("abort_nzp", 32'(nzp), 32'(NZP_RST));
    check("abort_dr_we", 32'(dr_we), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_write_r0", 32'(rf[0]), 32'h1234);
    check("abort_nzp_after", 32'(nzp), 32'(NZP_RST));

    for (int n = 0; n < 80; n++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: w[15:12] = 4'b0001;
        3, 4, 5: w[15:12] = 4'b0101;
        6, 7: begin
          w[15:12] = 4'b1001;
          if ($urandom_range(0, 1) == 1) w[5:0] = 6'h3F;
        end
        default: ;
      endcase
      issue(w);
      if ($urandom_range(0, 1) == 1) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    instr_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
